// File: rtl/fp_pkg.sv
// Shared floating-point definitions: default widths, operand classification
// record and the quiet-NaN encoding used by the FP add unit.
package fp_pkg;

   localparam int FP32_EXP_W = 8;
   localparam int FP32_MAN_W = 23;
   localparam int MAX_W      = 64;

   typedef struct packed {
      logic is_inf;
      logic is_zero;
      logic is_snan;
      logic is_qnan;
   } fp_class_t;

   // E4M3 has no infinity, so its only NaN pattern is all ones.
   function automatic logic [MAX_W-1:0] quiet_nan(input int e_w, input int m_w);
      logic [MAX_W-1:0] v;
      v = '0;
      for (int i = 0; i < e_w; i++) v[m_w+i] = 1'b1;
      v[e_w+m_w] = 1'b1;
      v[m_w-1]   = 1'b1;
      if (e_w == 4 && m_w == 3)
         for (int i = 0; i < m_w; i++) v[i] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/fp_add_core.sv
// Combinational FP add/subtract datapath: specials, alignment, signed add,
// normalization, range checks and rounding.
module fp_add_core import fp_pkg::*; #(
   parameter int EXPONENT_WIDTH   = 8,
   parameter int MANTISSA_WIDTH   = 23,
   parameter int ROUND_TO_NEAREST = 1,
   parameter int ROUNDING_BITS    = 3
) (
   input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
   input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
   input  logic                                   subtract,
   output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] result,
   output logic                                   underflow,
   output logic                                   overflow,
   output logic                                   invalid
);

   localparam int E   = EXPONENT_WIDTH;
   localparam int M   = MANTISSA_WIDTH;
   localparam int W   = E + M + 1;
   localparam int G   = ROUNDING_BITS * ROUND_TO_NEAREST;
   // With truncation there are no guard bits; keep one and clear it after alignment.
   localparam int GI  = (G > 0) ? G : 1;
   localparam int MX  = M + 1 + GI;
   localparam int NW  = MX + 1;
   localparam int NRM = M + GI;
   localparam int PW  = $clog2(NW) + 1;
   localparam int XW  = E + PW + 2;
   localparam logic [W-1:0]  QNAN    = W'(quiet_nan(E, M));
   localparam logic [XW-1:0] EXP_MAX = XW'({E{1'b1}});

   fp_class_t      ca, cb;
   logic           sa, sb, a_big, res_sign, zero_sum, exp_neg, rnd_carry;
   logic           nan_a, nan_b;
   logic [E-1:0]   ea, eb, diff, e_big;
   logic [MX-1:0]  ma, mb, ma_al, mb_al;
   logic [MX+1:0]  sum;
   logic [NW-1:0]  mag;
   logic [PW-1:0]  lead_pos, shamt;
   logic [NRM-1:0] norm;
   logic [M-1:0]   frac_rnd;
   logic [XW-1:0]  exp_n, exp_r;

   is_special_float #(.EXPONENT_WIDTH(E), .MANTISSA_WIDTH(M)) u_cls_a (.bits(a[W-2:0]), .cls(ca));
   is_special_float #(.EXPONENT_WIDTH(E), .MANTISSA_WIDTH(M)) u_cls_b (.bits(b[W-2:0]), .cls(cb));

   assign sa    = a[W-1];
   assign sb    = b[W-1] ^ subtract;
   assign ea    = a[W-2:M];
   assign eb    = b[W-2:M];
   assign ma    = {|ea, a[M-1:0], GI'(0)};
   assign mb    = {|eb, b[M-1:0], GI'(0)};
   assign a_big = (ea >= eb);
   assign diff  = a_big ? (ea - eb) : (eb - ea);
   assign e_big = a_big ? ea : eb;

   always_comb begin
      ma_al = a_big ? ma : (ma >> diff);
      mb_al = a_big ? (mb >> diff) : mb;
      if (G == 0) begin
         ma_al[0] = 1'b0;
         mb_al[0] = 1'b0;
      end
   end

   assign sum      = (sa ? -{2'b00, ma_al} : {2'b00, ma_al}) + (sb ? -{2'b00, mb_al} : {2'b00, mb_al});
   assign res_sign = sum[MX+1];
   assign mag      = NW'(res_sign ? -sum : sum);
   assign zero_sum = (mag == '0) || (ca.is_zero && cb.is_zero);

   leading_one_detector #(.N(NW), .PW(PW)) u_lod (.vec(mag), .pos(lead_pos));

   // Place the leading one at the top, then drop it and the bit below the guard field.
   assign shamt   = PW'(MX) - lead_pos;
   assign norm    = NRM'((mag << shamt) >> 1);
   assign exp_n   = XW'(e_big) + XW'(lead_pos) - XW'(NRM);
   assign exp_neg = exp_n[XW-1];

   result_rounder #(.MANTISSA_WIDTH(M), .GUARD_WIDTH(GI)) u_rnd (
      .frac     (norm[NRM-1:GI]),
      .guard    (norm[GI-1:0]),
      .round_en (ROUND_TO_NEAREST != 0),
      .frac_out (frac_rnd),
      .carry    (rnd_carry)
   );

   assign exp_r = exp_n + XW'(rnd_carry);
   assign nan_a = ca.is_snan | ca.is_qnan;
   assign nan_b = cb.is_snan | cb.is_qnan;

   always_comb begin
      result    = '0;
      underflow = 1'b0;
      overflow  = 1'b0;
      invalid   = 1'b0;
      if (nan_a || nan_b) begin
         result  = QNAN;
         invalid = ca.is_snan | cb.is_snan | (nan_a != nan_b);
      end else if (ca.is_inf && cb.is_inf && (sa != sb)) begin
         result  = QNAN;
         invalid = 1'b1;
      end else if (ca.is_inf && cb.is_inf) begin
         result   = {sa, {E{1'b1}}, {M{1'b0}}};
         overflow = 1'b1;
      end else if (zero_sum) begin
         result = '0;
      end else if (exp_neg) begin
         result    = {res_sign, {(W-1){1'b0}}};
         underflow = 1'b1;
      end else if (exp_n >= EXP_MAX || exp_r >= EXP_MAX) begin
         result   = {res_sign, {E{1'b1}}, {M{1'b0}}};
         overflow = 1'b1;
      end else begin
         result = {res_sign, exp_r[E-1:0], frac_rnd};
      end
   end

endmodule

// File: rtl/is_special_float.sv
// Classifies an {exp, frac} field pair as infinity, zero, signalling or quiet NaN.
module is_special_float import fp_pkg::*; #(
   parameter int EXPONENT_WIDTH = 8,
   parameter int MANTISSA_WIDTH = 23
) (
   input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH-1:0] bits,
   output fp_class_t                                cls
);

   logic exp_ones, exp_zero, frac_zero;

   assign exp_ones  = &bits[EXPONENT_WIDTH+MANTISSA_WIDTH-1:MANTISSA_WIDTH];
   assign exp_zero  = ~|bits[EXPONENT_WIDTH+MANTISSA_WIDTH-1:MANTISSA_WIDTH];
   assign frac_zero = ~|bits[MANTISSA_WIDTH-1:0];

   assign cls.is_inf  = exp_ones & frac_zero;
   assign cls.is_zero = exp_zero & frac_zero;
   assign cls.is_qnan = exp_ones & bits[MANTISSA_WIDTH-1];
   assign cls.is_snan = exp_ones & ~bits[MANTISSA_WIDTH-1] & ~frac_zero;

endmodule

// File: rtl/leading_one_detector.sv
// Returns the bit index of the most significant set bit (0 when the vector is empty).
module leading_one_detector #(
   parameter int N  = 8,
   parameter int PW = 4
) (
   input  logic [N-1:0]  vec,
   output logic [PW-1:0] pos
);

   always_comb begin
      pos = '0;
      for (int i = 0; i < N; i++)
         if (vec[i]) pos = PW'(i);
   end

endmodule

// File: rtl/result_rounder.sv
// Round-to-nearest-even on a normalized fraction, or plain truncation when disabled.
module result_rounder #(
   parameter int MANTISSA_WIDTH = 23,
   parameter int GUARD_WIDTH    = 3
) (
   input  logic [MANTISSA_WIDTH-1:0] frac,
   input  logic [GUARD_WIDTH-1:0]    guard,
   input  logic                      round_en,
   output logic [MANTISSA_WIDTH-1:0] frac_out,
   output logic                      carry
);

   localparam logic [GUARD_WIDTH-1:0] HALF = GUARD_WIDTH'(1) << (GUARD_WIDTH - 1);

   logic up;

   assign up       = round_en && ((guard > HALF) || (guard == HALF && frac[0]));
   assign frac_out = frac + MANTISSA_WIDTH'(up);
   // The implicit one is always set, so an all-ones fraction wraps into the exponent.
   assign carry    = up & (&frac);

endmodule

// File: rtl/fp_add_sub_reg.sv
// Floating-point adder/subtractor with a one-cycle registered result and flags.
module fp_add_sub_reg import fp_pkg::*; #(
   parameter int EXPONENT_WIDTH   = FP32_EXP_W,
   parameter int MANTISSA_WIDTH   = FP32_MAN_W,
   parameter int ROUND_TO_NEAREST = 1,
   parameter int ROUNDING_BITS    = 3
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   in_valid,
   input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
   input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
   input  logic                                   subtract,
   output logic                                   out_valid,
   output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out,
   output logic                                   underflow_flag,
   output logic                                   overflow_flag,
   output logic                                   invalid_operation_flag
);

   logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] result_nxt;
   logic underflow_nxt, overflow_nxt, invalid_nxt;

   fp_add_core #(
      .EXPONENT_WIDTH   (EXPONENT_WIDTH),
      .MANTISSA_WIDTH   (MANTISSA_WIDTH),
      .ROUND_TO_NEAREST (ROUND_TO_NEAREST),
      .ROUNDING_BITS    (ROUNDING_BITS)
   ) u_core (
      .a         (a),
      .b         (b),
      .subtract  (subtract),
      .result    (result_nxt),
      .underflow (underflow_nxt),
      .overflow  (overflow_nxt),
      .invalid   (invalid_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid              <= 1'b0;
         out                    <= '0;
         underflow_flag         <= 1'b0;
         overflow_flag          <= 1'b0;
         invalid_operation_flag <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out                    <= result_nxt;
            underflow_flag         <= underflow_nxt;
            overflow_flag          <= overflow_nxt;
            invalid_operation_flag <= invalid_nxt;
         end
      end
   end

endmodule

// File: tb/tb_fp_add_sub_reg.sv
// Directed and randomized FP32 checks of fp_add_sub_reg against an arithmetic reference model.
module tb_fp_add_sub_reg;

   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, subtract = 1'b0;
   logic [31:0] a = '0, b = '0, out;
   logic        out_valid, uf, of, inv;
   int          n_tests = 0, n_fail = 0;
   logic [31:0] last_r;
   logic [2:0]  last_f;

   always #5 clk = ~clk;

   fp_add_sub_reg #(
      .EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .ROUND_TO_NEAREST(1), .ROUNDING_BITS(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .subtract(subtract),
      .out_valid(out_valid), .out(out), .underflow_flag(uf), .overflow_flag(of),
      .invalid_operation_flag(inv)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic apply(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic sub, input logic [31:0] er, input logic [2:0] ef);
      @(negedge clk);
      a = x; b = y; subtract = sub; in_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, ":out"}, out, er);
      check({tag, ":flags(uf,of,inv)"}, {29'b0, uf, of, inv}, {29'b0, ef});
      check({tag, ":out_valid"}, {31'b0, out_valid}, 32'd1);
      last_r = er; last_f = ef;
   endtask

   // Reference: exact integer arithmetic on (implicit.frac << 3) magnitudes.
   function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic sub,
                                 output logic [31:0] r, output logic [2:0] f);
      int ex, ey, e, p;
      logic sx, sy, sign, xnan, ynan, xsn, ysn, xinf, yinf;
      longint mx, my, s, m, frac, g;
      sx = x[31]; sy = y[31] ^ sub;
      ex = int'(x[30:23]); ey = int'(y[30:23]);
      xnan = (ex == 255) && (x[22:0] != 0); ynan = (ey == 255) && (y[22:0] != 0);
      xsn = xnan && !x[22]; ysn = ynan && !y[22];
      xinf = (ex == 255) && (x[22:0] == 0); yinf = (ey == 255) && (y[22:0] == 0);
      f = 3'b000;
      if (xnan || ynan) begin
         r = 32'hFFC0_0000; f = {2'b00, xsn || ysn || (xnan != ynan)}; return;
      end
      if (xinf && yinf) begin
         if (sx != sy) begin r = 32'hFFC0_0000; f = 3'b001; end
         else begin r = {sx, 8'hFF, 23'h0}; f = 3'b010; end
         return;
      end
      mx = longint'(x[22:0]); if (ex != 0) mx += 64'sd1 << 23; mx = mx << 3;
      my = longint'(y[22:0]); if (ey != 0) my += 64'sd1 << 23; my = my << 3;
      if (ex >= ey) begin my = (ex - ey > 40) ? 0 : (my >> (ex - ey)); e = ex; end
      else begin mx = (ey - ex > 40) ? 0 : (mx >> (ey - ex)); e = ey; end
      s = (sx ? -mx : mx) + (sy ? -my : my);
      if (s == 0) begin r = 32'h0; return; end
      sign = (s < 0); m = sign ? -s : s;
      p = 0;
      for (int i = 0; i < 40; i++) if (m[i]) p = i;
      e = e + p - 26;
      if (e < 0)    begin r = {sign, 31'h0}; f = 3'b100; return; end
      if (e >= 255) begin r = {sign, 8'hFF, 23'h0}; f = 3'b010; return; end
      if (p > 26) m = m >> (p - 26); else m = m << (26 - p);
      frac = (m >> 3) & 64'h7F_FFFF; g = m & 7;
      if (g > 4 || (g == 4 && frac[0])) frac++;
      if (frac == (64'sd1 << 23)) begin frac = 0; e++; end
      if (e >= 255) begin r = {sign, 8'hFF, 23'h0}; f = 3'b010; return; end
      r = {sign, e[7:0], frac[22:0]};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] v;
      int k;
      k = int'($urandom_range(0, 19));
      v = $urandom;
      case (k)
         0: v[30:0] = '0;
         1: v[30:0] = {8'hFF, 23'h0};
         2: v[30:23] = 8'hFF;
         3: v[30:23] = 8'h00;
         4, 5: v[30:23] = 8'($urandom_range(1, 254));
         6: v[30:23] = 8'($urandom_range(250, 254));
         7: v[30:23] = 8'($urandom_range(1, 5));
         default: v[30:23] = 8'($urandom_range(120, 135));
      endcase
      return v;
   endfunction

   initial begin
      logic [31:0] x, y, er;
      logic [2:0]  ef;
      logic        sub;

      #12;
      check("reset:out", out, 32'h0);
      check("reset:flags", {29'b0, uf, of, inv}, 32'h0);
      check("reset:out_valid", {31'b0, out_valid}, 32'h0);
      @(negedge clk); rst_n = 1'b1;

      apply("1+2",        32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 3'b000);
      apply("1-1",        32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 3'b000);
      apply("tie_even",   32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 3'b000);
      apply("above_half", 32'h3F80_0000, 32'h33C0_0000, 1'b0, 32'h3F80_0001, 3'b000);
      apply("inf-inf",    32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'hFFC0_0000, 3'b001);
      apply("inf+inf",    32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h7F80_0000, 3'b010);
      apply("max+max",    32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b010);
      apply("snan+1",     32'h7FA0_0000, 32'h3F80_0000, 1'b0, 32'hFFC0_0000, 3'b001);
      apply("qnan+1",     32'h7FC0_0000, 32'h3F80_0000, 1'b0, 32'hFFC0_0000, 3'b001);
      apply("qnan+qnan",  32'h7FC0_0000, 32'hFFC0_0001, 1'b0, 32'hFFC0_0000, 3'b000);
      apply("inf-(-inf)", 32'h7F80_0000, 32'hFF80_0000, 1'b1, 32'h7F80_0000, 3'b010);
      apply("1-2",        32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000, 3'b000);

      for (int i = 0; i < 400; i++) begin
         x = rand_op();
         if ($urandom_range(0, 3) == 0) y = x ^ ($urandom & 32'h0000_03FF);
         else y = rand_op();
         sub = 1'($urandom_range(0, 1));
         model(x, y, sub, er, ef);
         apply("rand", x, y, sub, er, ef);
      end

      @(negedge clk);
      in_valid = 1'b0; a = 32'h4120_0000; b = 32'h4120_0000; subtract = 1'b0;
      @(posedge clk); #1;
      check("hold:out", out, last_r);
      check("hold:flags", {29'b0, uf, of, inv}, {29'b0, last_f});
      check("hold:out_valid", {31'b0, out_valid}, 32'h0);

      apply("pre_reset", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b010);
      @(negedge clk); #2;
      rst_n = 1'b0; #1;
      check("async_reset:out", out, 32'h0);
      check("async_reset:flags", {29'b0, uf, of, inv}, 32'h0);
      check("async_reset:out_valid", {31'b0, out_valid}, 32'h0);
      @(negedge clk); rst_n = 1'b1;
      apply("post_reset", 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 3'b000);
      @(negedge clk); in_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
